// File: rtl/cla_seq_pkg.sv
// Shared types and constants for the nibble-serial CLA adder.
package cla_seq_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/cla_seq_adder_cla4.sv
// 4-bit carry look-ahead adder; all carries derived directly from generate/propagate terms.
module cla_seq_adder_cla4 (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       cin,
  output logic [3:0] S,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = A & B;
  assign p = A ^ B;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign S    = p ^ c[3:0];
  assign cout = c[4];

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle WIDTH-bit adder reusing one 4-bit CLA, one nibble per cycle, valid/ready on both sides.
// Define CLA_SEQ_SUB_EN to add the op_sub port (a - b via inverted b and carry-in of 1).
module cla_seq_adder
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
  input  logic             op_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  state_t state, state_next;

  logic [NIB-1:0][NIBBLE_W-1:0] a_r;
  logic [NIB-1:0][NIBBLE_W-1:0] b_r;
  logic [NIB-1:0][NIBBLE_W-1:0] sum_r;
  logic                         carry_r;
  logic                         cout_r;
  logic [IDX_W-1:0]             idx;
  logic                         last;

  logic [WIDTH-1:0]    b_eff;
  logic                cin_eff;
  logic [NIBBLE_W-1:0] cla_s;
  logic                cla_co;

`ifdef CLA_SEQ_SUB_EN
  assign b_eff   = op_sub ? ~b : b;
  assign cin_eff = op_sub | cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  assign last = (idx == IDX_W'(NIB - 1));

  cla_seq_adder_cla4 u_cla (
    .A    (a_r[idx]),
    .B    (b_r[idx]),
    .cin  (carry_r),
    .S    (cla_s),
    .cout (cla_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Carry chains nibble-to-nibble through carry_r; cout_r only updates on the final nibble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      idx     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r     <= a;
            b_r     <= b_eff;
            carry_r <= cin_eff;
            idx     <= '0;
          end
        end
        RUN: begin
          sum_r[idx] <= cla_s;
          carry_r    <= cla_co;
          if (last) begin
            cout_r <= cla_co;
            idx    <= '0;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_r;
  assign cout = cout_r;

endmodule
